turn_controller: RTL and testbench
==================================

Name: turn_controller

Overview:
Sequences a two-board, two-player game once the local player identity is chosen.
- Consumes the 2-bit selected-player code (00 none, 01 player 1, 11 player 2).
- Runs start, alternating turns, turn timeout, scoring and game-over.
- Gates which side (local buttons or remote UART link) may move.
- Sits between the player selector, the input/UART decoders and the VGA drawing/game-logic blocks.

Parameters:
TURN_TICKS, 10, tick pulses allowed per turn before timeout (1..255)
WIN_SCORE, 5, hits needed to win (1..15)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
selected_player  input  2  from player selector: 00 none, 01 player 1, 11 player 2
tick  input  1  single-cycle time-base pulse for the turn timer
start  input  1  pulse: begin game from READY
restart  input  1  pulse: leave GAME_OVER
local_move  input  1  pulse: local player committed a move
local_hit  input  1  qualifies local_move: move scored
remote_move  input  1  pulse: remote player's move received
remote_hit  input  1  qualifies remote_move
state_o  output  3  0 WAIT_SELECT, 1 READY, 2 TURN_P1, 3 TURN_P2, 4 GAME_OVER
active_player  output  2  01 in TURN_P1, 11 in TURN_P2, else 00
my_turn  output  1  1 when the active side equals the latched local identity
time_left  output  8  remaining ticks in current turn
score_p1  output  4  player 1 hits
score_p2  output  4  player 2 hits
winner  output  2  00 none, 01 player 1, 11 player 2
turn_end  output  1  one-cycle pulse when a turn passes (move or timeout)
timeout  output  1  one-cycle pulse when a turn expired

Behaviour:
- Outputs are registered and update on the clock edge after the causing input.
- rst: state WAIT_SELECT, local_id 00, all outputs 0 (time_left 0, winner 00). rst wins over every other input and aborts any state, including mid-turn.
- WAIT_SELECT:
  - selected_player 01 or 11: latch local_id, go to READY.
  - selected_player 00 or 10: stay.
  - Later changes on selected_player are ignored until rst.
- READY: start goes to TURN_P1 (player 1 always opens), time_left=TURN_TICKS, scores 0, winner 00.
- TURN_Px: active side is local when local_id equals active_player, else remote.
  - Moves from the inactive side are ignored.
  - Active-side move with hit: score_px+1. If the new value equals WIN_SCORE, go to GAME_OVER, winner=active_player, turn_end=1. Otherwise go to the other TURN state, time_left=TURN_TICKS, turn_end=1.
  - Active-side move without hit: go to the other TURN state, reload timer, turn_end=1, score unchanged.
  - tick with no move and time_left>1: decrement.
  - tick with no move and time_left==1: decrement to 0, pass turn, reload, turn_end=1, timeout=1.
  - Move and tick in the same cycle: the move wins and the tick is dropped (no timeout).
  - *_hit without a move pulse is ignored.
- GAME_OVER: time_left 0, active_player 00, my_turn 0; scores and winner held. restart goes to READY with scores and winner cleared. start is ignored here.
- start/restart outside their states are ignored.
- Scores never exceed WIN_SCORE and never wrap.

Test Plan:
- rst, selected_player=00 for 5 cycles: state_o=0. Then selected_player=11: state_o=1 next cycle; later selected_player=01 has no effect (local_id stays 11).
- local_id=01, TURN_TICKS=3, start: state_o=2, active_player=01, my_turn=1, time_left=3. local_move+local_hit: score_p1=1, state_o=3, my_turn=0, turn_end pulse.
- In TURN_P2 with local_id=01: local_move ignored. 3 ticks: time_left 2,1 then timeout=1 and turn_end=1, state_o=2, time_left=3, scores unchanged.
- local_move and tick in the same cycle at time_left=1: turn passes with timeout=0.
- WIN_SCORE=2: alternate hits P1, P2, P1: state_o=4, winner=01, score_p1=2, score_p2=1. restart: state_o=1, scores 0, winner 00.
- rst asserted mid-TURN_P2: next cycle all outputs 0, state_o=0.

Source files
------------

// File: rtl/turn_controller_if.sv
// Control/status bundle between the turn controller and its neighbours
// (player selector, input/UART decoders, VGA and game-logic blocks).
interface turn_controller_if;
    logic [1:0] selected_player;
    logic       tick;
    logic       start;
    logic       restart;
    logic       local_move;
    logic       local_hit;
    logic       remote_move;
    logic       remote_hit;

    logic [2:0] state_o;
    logic [1:0] active_player;
    logic       my_turn;
    logic [7:0] time_left;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [1:0] winner;
    logic       turn_end;
    logic       timeout;

    modport master (
        output selected_player, tick, start, restart,
               local_move, local_hit, remote_move, remote_hit,
        input  state_o, active_player, my_turn, time_left,
               score_p1, score_p2, winner, turn_end, timeout
    );

    modport slave (
        input  selected_player, tick, start, restart,
               local_move, local_hit, remote_move, remote_hit,
        output state_o, active_player, my_turn, time_left,
               score_p1, score_p2, winner, turn_end, timeout
    );
endinterface

// File: rtl/turn_controller.sv
// Two-player turn sequencer: start, alternating timed turns, scoring,
// game-over, and gating of which side (local or remote) may move.
module turn_controller #(
    parameter int unsigned TURN_TICKS = 10,
    parameter int unsigned WIN_SCORE  = 5
) (
    input  logic             clk,
    input  logic             rst,
    turn_controller_if.slave bus
);
    localparam int unsigned TIME_W  = 8;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned ID_W    = 2;

    localparam logic [ID_W-1:0]    ID_NONE  = 2'b00;
    localparam logic [ID_W-1:0]    ID_P1    = 2'b01;
    localparam logic [ID_W-1:0]    ID_P2    = 2'b11;
    localparam logic [TIME_W-1:0]  T_RELOAD = TIME_W'(TURN_TICKS);
    localparam logic [SCORE_W-1:0] S_WIN    = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_WAIT_SELECT = 3'd0,
        ST_READY       = 3'd1,
        ST_TURN_P1     = 3'd2,
        ST_TURN_P2     = 3'd3,
        ST_GAME_OVER   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     local_id_q, local_id_d;
    logic [TIME_W-1:0]   time_left_q, time_left_d;
    logic [SCORE_W-1:0]  score_p1_q, score_p1_d;
    logic [SCORE_W-1:0]  score_p2_q, score_p2_d;
    logic [ID_W-1:0]     winner_q, winner_d;
    logic [ID_W-1:0]     active_q, active_d;
    logic                my_turn_q, my_turn_d;
    logic                turn_end_q, turn_end_d;
    logic                timeout_q, timeout_d;

    logic [ID_W-1:0]     turn_id;
    logic                move;
    logic                hit;
    logic [SCORE_W-1:0]  score_inc;
    state_e              other_turn;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT_SELECT;
            local_id_q  <= ID_NONE;
            time_left_q <= '0;
            score_p1_q  <= '0;
            score_p2_q  <= '0;
            winner_q    <= ID_NONE;
            active_q    <= ID_NONE;
            my_turn_q   <= 1'b0;
            turn_end_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            local_id_q  <= local_id_d;
            time_left_q <= time_left_d;
            score_p1_q  <= score_p1_d;
            score_p2_q  <= score_p2_d;
            winner_q    <= winner_d;
            active_q    <= active_d;
            my_turn_q   <= my_turn_d;
            turn_end_q  <= turn_end_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        local_id_d  = local_id_q;
        time_left_d = time_left_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        winner_d    = winner_q;
        turn_end_d  = 1'b0;
        timeout_d   = 1'b0;

        turn_id    = (state_q == ST_TURN_P1) ? ID_P1 : ID_P2;
        other_turn = (state_q == ST_TURN_P1) ? ST_TURN_P2 : ST_TURN_P1;
        // Only the side owning the current turn may move
        move       = (local_id_q == turn_id) ? bus.local_move : bus.remote_move;
        hit        = (local_id_q == turn_id) ? bus.local_hit  : bus.remote_hit;
        score_inc  = ((state_q == ST_TURN_P1) ? score_p1_q : score_p2_q) + SCORE_W'(1);

        case (state_q)
            ST_WAIT_SELECT: begin
                if (bus.selected_player == ID_P1 || bus.selected_player == ID_P2) begin
                    local_id_d = bus.selected_player;
                    state_d    = ST_READY;
                end
            end
            ST_READY: begin
                if (bus.start) begin
                    state_d     = ST_TURN_P1;
                    time_left_d = T_RELOAD;
                    score_p1_d  = '0;
                    score_p2_d  = '0;
                    winner_d    = ID_NONE;
                end
            end
            ST_TURN_P1, ST_TURN_P2: begin
                if (move) begin
                    turn_end_d  = 1'b1;
                    state_d     = other_turn;
                    time_left_d = T_RELOAD;
                    if (hit) begin
                        if (state_q == ST_TURN_P1) score_p1_d = score_inc;
                        else                       score_p2_d = score_inc;
                        if (score_inc == S_WIN) begin
                            state_d     = ST_GAME_OVER;
                            winner_d    = turn_id;
                            time_left_d = '0;
                        end
                    end
                end else if (bus.tick) begin
                    if (time_left_q > TIME_W'(1)) begin
                        time_left_d = time_left_q - TIME_W'(1);
                    end else begin
                        state_d     = other_turn;
                        time_left_d = T_RELOAD;
                        turn_end_d  = 1'b1;
                        timeout_d   = 1'b1;
                    end
                end
            end
            ST_GAME_OVER: begin
                time_left_d = '0;
                if (bus.restart) begin
                    state_d    = ST_READY;
                    score_p1_d = '0;
                    score_p2_d = '0;
                    winner_d   = ID_NONE;
                end
            end
            default: state_d = ST_WAIT_SELECT;
        endcase

        case (state_d)
            ST_TURN_P1: active_d = ID_P1;
            ST_TURN_P2: active_d = ID_P2;
            default:    active_d = ID_NONE;
        endcase
        my_turn_d = (active_d != ID_NONE) && (active_d == local_id_d);
    end

    assign bus.state_o       = 3'(state_q);
    assign bus.active_player = active_q;
    assign bus.my_turn       = my_turn_q;
    assign bus.time_left     = time_left_q;
    assign bus.score_p1      = score_p1_q;
    assign bus.score_p2      = score_p2_q;
    assign bus.winner        = winner_q;
    assign bus.turn_end      = turn_end_q;
    assign bus.timeout       = timeout_q;

endmodule

// File: tb/tb_turn_controller.sv
// Directed-vector bench for turn_controller (TURN_TICKS=3, WIN_SCORE=2).
module tb_turn_controller;
    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    turn_controller_if bus ();

    turn_controller #(
        .TURN_TICKS(3),
        .WIN_SCORE (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock; pulse inputs are cleared right after the edge
    task automatic step();
        @(posedge clk);
        #1;
        bus.tick        = 1'b0;
        bus.start       = 1'b0;
        bus.restart     = 1'b0;
        bus.local_move  = 1'b0;
        bus.local_hit   = 1'b0;
        bus.remote_move = 1'b0;
        bus.remote_hit  = 1'b0;
    endtask

    task automatic check_core(input string tag, input logic [7:0] st, input logic [7:0] tl,
                              input logic [7:0] s1, input logic [7:0] s2);
        check_eq({tag, ".state"}, 8'(bus.state_o), st);
        check_eq({tag, ".time_left"}, bus.time_left, tl);
        check_eq({tag, ".score_p1"}, 8'(bus.score_p1), s1);
        check_eq({tag, ".score_p2"}, 8'(bus.score_p2), s2);
    endtask

    task automatic check_turn(input string tag, input logic [7:0] ap, input logic [7:0] mt,
                              input logic [7:0] te, input logic [7:0] to);
        check_eq({tag, ".active"}, 8'(bus.active_player), ap);
        check_eq({tag, ".my_turn"}, 8'(bus.my_turn), mt);
        check_eq({tag, ".turn_end"}, 8'(bus.turn_end), te);
        check_eq({tag, ".timeout"}, 8'(bus.timeout), to);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        bus.selected_player = 2'b00;
        bus.tick = 1'b0; bus.start = 1'b0; bus.restart = 1'b0;
        bus.local_move = 1'b0; bus.local_hit = 1'b0;
        bus.remote_move = 1'b0; bus.remote_hit = 1'b0;

        step(); step();
        check_core("rst", 0, 0, 0, 0);
        check_turn("rst", 0, 0, 0, 0);
        check_eq("rst.winner", 8'(bus.winner), 0);

        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_eq("sel00.state", 8'(bus.state_o), 0);
        bus.selected_player = 2'b10;
        step();
        check_eq("sel10.state", 8'(bus.state_o), 0);

        // Latch id 11; later 01 must be ignored
        bus.selected_player = 2'b11;
        step();
        check_eq("sel11.state", 8'(bus.state_o), 1);
        bus.selected_player = 2'b01;
        step(); step();
        check_eq("sel01_late.state", 8'(bus.state_o), 1);
        bus.start = 1'b1;
        step();
        check_core("start_id11", 2, 3, 0, 0);
        check_turn("start_id11", 1, 0, 0, 0);

        // Reset mid-turn and reselect as player 1
        rst = 1'b1;
        step();
        check_core("rst_mid", 0, 0, 0, 0);
        check_turn("rst_mid", 0, 0, 0, 0);
        rst = 1'b0;
        step();
        check_eq("sel01.state", 8'(bus.state_o), 1);
        bus.selected_player = 2'b11;
        bus.start = 1'b1;
        step();
        check_core("start_id01", 2, 3, 0, 0);
        check_turn("start_id01", 1, 1, 0, 0);

        bus.tick = 1'b1;
        step();
        check_core("p1_tick", 2, 2, 0, 0);
        bus.remote_move = 1'b1; bus.remote_hit = 1'b1;
        step();
        check_core("p1_remote_ign", 2, 2, 0, 0);
        bus.local_hit = 1'b1;
        step();
        check_core("p1_hit_only", 2, 2, 0, 0);

        bus.local_move = 1'b1; bus.local_hit = 1'b1;
        step();
        check_core("p1_hit", 3, 3, 1, 0);
        check_turn("p1_hit", 3, 0, 1, 0);
        step();
        check_eq("p1_hit_pulse.turn_end", 8'(bus.turn_end), 0);

        // P2 turn is remote for local id 01
        bus.local_move = 1'b1; bus.local_hit = 1'b1;
        step();
        check_core("p2_local_ign", 3, 3, 1, 0);
        bus.tick = 1'b1; step();
        check_core("p2_tick1", 3, 2, 1, 0);
        bus.tick = 1'b1; step();
        check_core("p2_tick2", 3, 1, 1, 0);
        bus.tick = 1'b1; step();
        check_core("p2_timeout", 2, 3, 1, 0);
        check_turn("p2_timeout", 1, 1, 1, 1);
        step();
        check_eq("p2_timeout_pulse.timeout", 8'(bus.timeout), 0);

        // Move and tick together at time_left=1: move wins
        bus.tick = 1'b1; step();
        bus.tick = 1'b1; step();
        check_eq("p1_tl1.time_left", bus.time_left, 1);
        bus.tick = 1'b1; bus.local_move = 1'b1;
        step();
        check_core("move_tick", 3, 3, 1, 0);
        check_turn("move_tick", 3, 0, 1, 0);

        bus.remote_move = 1'b1; bus.remote_hit = 1'b1;
        step();
        check_core("p2_hit", 2, 3, 1, 1);
        check_turn("p2_hit", 1, 1, 1, 0);

        bus.local_move = 1'b1; bus.local_hit = 1'b1;
        step();
        check_core("p1_win", 4, 0, 2, 1);
        check_turn("p1_win", 0, 0, 1, 0);
        check_eq("p1_win.winner", 8'(bus.winner), 8'h01);

        bus.start = 1'b1; bus.tick = 1'b1;
        step();
        check_core("go_start_ign", 4, 0, 2, 1);
        check_eq("go_start_ign.winner", 8'(bus.winner), 8'h01);

        bus.restart = 1'b1;
        step();
        check_core("restart", 1, 0, 0, 0);
        check_eq("restart.winner", 8'(bus.winner), 0);
        bus.restart = 1'b1;
        step();
        check_eq("ready_restart_ign.state", 8'(bus.state_o), 1);

        bus.start = 1'b1; step();
        check_core("start2", 2, 3, 0, 0);
        bus.local_move = 1'b1; step();
        check_core("p1_miss", 3, 3, 0, 0);
        check_turn("p1_miss", 3, 0, 1, 0);
        bus.tick = 1'b1; step();
        check_core("p2_tick_b", 3, 2, 0, 0);

        rst = 1'b1; bus.remote_move = 1'b1; bus.remote_hit = 1'b1;
        step();
        check_core("rst_p2", 0, 0, 0, 0);
        check_turn("rst_p2", 0, 0, 0, 0);
        check_eq("rst_p2.winner", 8'(bus.winner), 0);
        rst = 1'b0; bus.selected_player = 2'b00;
        step();
        check_eq("rst_p2_sel00.state", 8'(bus.state_o), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
